tx_top: RTL and testbench
=========================

TX_TOP -- requirements
Module: tx_top

Interface
REQ-001 SHALL provide parameter clk_speed, default 100_000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter baudrate, default 921600, line bit rate in bits/s.
REQ-003 SHALL provide parameter D_BITS, default 8, data bits per frame (range 5..9).
REQ-004 SHALL provide parameter SP_BITS, default 1, stop bits per frame (range 1..2).
REQ-005 SHALL provide port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL provide port i_rst_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL provide port i_data  input  D_BITS  byte to transmit; sampled only on an accepted start.
REQ-008 SHALL provide port i_tx_start  input  1  transmit request, level-sampled each cycle.
REQ-009 SHALL provide port o_tx  output  1  serial line; idle high.
REQ-010 SHALL provide port o_tx_busy  output  1  high from acceptance until frame end.
REQ-011 SHALL provide port o_tx_done  output  1  single-cycle pulse at frame end.

Function
REQ-012 SHALL derive BIT_CYCLES = clk_speed / baudrate (integer truncation; 108 at defaults) and hold every bit on o_tx for exactly BIT_CYCLES cycles.
REQ-013 SHALL use an internal bit-period counter, cleared on start acceptance and on every bit boundary; counter width = $clog2(BIT_CYCLES).
REQ-014 SHALL implement states IDLE, START, DATA, (PARITY), STOP.
REQ-015 IDLE: o_tx=1, o_tx_busy=0; i_tx_start=1 -> latch i_data into a shift register, set o_tx_busy=1, go to START.
REQ-016 START: drive o_tx=0 from the cycle after acceptance for BIT_CYCLES cycles, then go to DATA.
REQ-017 DATA: drive D_BITS bits LSB first, one per bit period; after bit D_BITS-1, go to PARITY if compiled in, otherwise STOP.
REQ-018 STOP: drive o_tx=1 for SP_BITS*BIT_CYCLES cycles.
REQ-019 On the last cycle of STOP, assert o_tx_done for exactly one cycle, then return to IDLE; o_tx_busy falls with the IDLE entry.
REQ-020 Frame latency: first start-bit cycle is 1 cycle after acceptance; frame length is (1+D_BITS+P+SP_BITS)*BIT_CYCLES cycles, where P=1 with parity and P=0 without.
REQ-021 i_tx_start while o_tx_busy=1 SHALL be ignored; i_data changes during a frame SHALL NOT affect the frame.
REQ-022 i_tx_start held high continuously SHALL start a new frame on the first IDLE cycle after o_tx_done, with no additional idle time beyond that cycle.
REQ-023 o_tx SHALL be a registered output with no combinational glitches.

Reset
REQ-024 When i_rst_n=0 at a clock edge: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, counters and shift register cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately: o_tx=1 on the next edge, no o_tx_done pulse.
REQ-026 i_tx_start coincident with i_rst_n=0 SHALL be ignored.

Configuration
REQ-027 Macro TX_PARITY_EN defined: insert an even-parity bit (XOR of the latched data bits) after DATA, lasting BIT_CYCLES cycles.
REQ-028 TX_PARITY_EN undefined: no PARITY state; DATA proceeds directly to STOP.

Verification
REQ-029 Defaults, no parity: i_data=0x55, start pulse at cycle T -> o_tx=0 during T+1..T+108, then bits 1,0,1,0,1,0,1,0 at 108 cycles each, then high; o_tx_done at T+1080, o_tx_busy high T+1..T+1080.
REQ-030 Start ignored: second i_tx_start with i_data=0xFF at T+500 during a 0xA3 frame -> line carries 0xA3 only; exactly one o_tx_done.
REQ-031 Back-to-back: i_tx_start held high with 0x01 then 0x80 -> two frames, second start bit begins 2 cycles after the first o_tx_done.
REQ-032 Reset mid-frame: i_rst_n=0 at T+300 -> o_tx=1, busy=0 next cycle, no done pulse; a later start sends a full, clean frame.
REQ-033 TX_PARITY_EN, i_data=0x07 -> parity bit=1 after bit 7; i_data=0x03 -> parity bit=0; o_tx_done at T+1188.
REQ-034 D_BITS=7, SP_BITS=2, i_data=0x41 -> 7 data bits, 216-cycle stop period, o_tx_done at T+1080.

Source files
------------

// File: rtl/tx_top.sv
// UART transmitter: start bit, D_BITS data bits LSB first, optional even parity, SP_BITS stop bits.
// Define TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
`timescale 1ns/1ps

module tx_top #(
  parameter int clk_speed = 100_000000,
  parameter int baudrate  = 921600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_tx_start,
  output logic              o_tx,
  output logic              o_tx_busy,
  output logic              o_tx_done
);

  localparam int BIT_CYCLES = clk_speed / baudrate;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(D_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(D_BITS - 1);
  localparam logic          SP_LAST  = 1'(SP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [BW-1:0]     bit_idx, bit_idx_n;
  logic              sp_idx, sp_idx_n;
  logic [D_BITS-1:0] shreg, shreg_n;
  logic              tx_q, tx_n;
  logic              bit_end;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_n;
`endif

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sp_idx   <= 1'b0;
      shreg    <= '0;
      tx_q     <= 1'b1;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      sp_idx   <= sp_idx_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
`ifdef TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  // tx_n is the line level for the next cycle, so the line leaves a flop and the
  // start bit appears exactly one cycle after the start request is accepted.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    sp_idx_n  = sp_idx;
    shreg_n   = shreg;
    tx_n      = tx_q;
`ifdef TX_PARITY_EN
    parity_n  = parity_q;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (i_tx_start) begin
          state_n   = START;
          shreg_n   = i_data;
          bit_idx_n = '0;
          sp_idx_n  = 1'b0;
          tx_n      = 1'b0;
`ifdef TX_PARITY_EN
          parity_n  = ^i_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == BIT_LAST) begin
`ifdef TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + BW'(1);
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (sp_idx == SP_LAST) state_n = IDLE;
          else                   sp_idx_n = sp_idx + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = (state != IDLE);
  assign o_tx_done = (state == STOP) && bit_end && (sp_idx == SP_LAST);

endmodule

// File: tb/tb_tx_top.sv
// Self-checking bench for tx_top: compares captured line/busy/done traces against a frame model.
// Follows TX_PARITY_EN the same way the design does.
`timescale 1ns/1ps

module tb_tx_top;

  localparam int BC   = 100_000000 / 921600;
`ifdef TX_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int MAXC = 2400;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int compared   = 0;
  int mismatched = 0;

  logic cap_tx   [0:MAXC-1];
  logic cap_busy [0:MAXC-1];
  logic cap_done [0:MAXC-1];
  logic exp_tx   [0:MAXC-1];
  logic exp_busy [0:MAXC-1];
  logic exp_done [0:MAXC-1];

  tx_top dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_tx_start (start0),
    .o_tx       (tx0),
    .o_tx_busy  (busy0),
    .o_tx_done  (done0)
  );

  tx_top #(.D_BITS(7), .SP_BITS(2)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data[6:0]),
    .i_tx_start (start1),
    .o_tx       (tx1),
    .o_tx_busy  (busy1),
    .o_tx_done  (done1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int frame_len(input int dbits, input int sp);
    return (1 + dbits + PAR + sp) * BC;
  endfunction

  function automatic void clear_exp();
    for (int k = 0; k < MAXC; k++) begin
      exp_tx[k]   = 1'b1;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
  endfunction

  // Builds the frame's bit list, then stretches every bit over BC cycles starting at cycle off+1.
  function automatic void add_frame(input int off, input logic [7:0] d, input int dbits, input int sp);
    int   bits[$];
    int   len;
    logic p;
    p = 1'b0;
    bits.push_back(0);
    for (int i = 0; i < dbits; i++) begin
      bits.push_back(int'(d[i]));
      p = p ^ d[i];
    end
    if (PAR == 1) bits.push_back(int'(p));
    for (int i = 0; i < sp; i++) bits.push_back(1);
    len = bits.size() * BC;
    for (int k = 1; k <= len; k++) begin
      exp_tx[off+k]   = (bits[(k-1)/BC] != 0);
      exp_busy[off+k] = 1'b1;
      exp_done[off+k] = (k == len);
    end
  endfunction

  function automatic logic cap_val(input int w, input int k);
    return (w == 0) ? cap_tx[k] : (w == 1) ? cap_busy[k] : cap_done[k];
  endfunction

  function automatic logic exp_val(input int w, input int k);
    return (w == 0) ? exp_tx[k] : (w == 1) ? exp_busy[k] : exp_done[k];
  endfunction

  function automatic string sig_name(input int w);
    return (w == 0) ? "o_tx" : (w == 1) ? "o_tx_busy" : "o_tx_done";
  endfunction

  function automatic int first_diff(input int n, input int w);
    for (int k = 1; k <= n; k++)
      if (cap_val(w, k) !== exp_val(w, k)) return k;
    return -1;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // Cycle T is the cycle whose closing edge accepts the start; index k holds cycle T+k.
  // inj_kind 1 pulses start with inj_data during cycle T+inj_at, inj_kind 2 pulses reset.
  task automatic capture(input int sel, input int n, input logic [7:0] first_data,
                         input int start_until, input logic [7:0] next_data,
                         input int inj_at, input int inj_kind, input logic [7:0] inj_data);
    @(negedge clk);
    rst_n = 1'b1;
    data  = first_data;
    set_start(sel, 1'b1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_tx[k]   = (sel == 0) ? tx0   : tx1;
      cap_busy[k] = (sel == 0) ? busy0 : busy1;
      cap_done[k] = (sel == 0) ? done0 : done1;
      data  = next_data;
      rst_n = 1'b1;
      set_start(sel, k <= start_until);
      if (k == inj_at) begin
        if (inj_kind == 1) begin
          set_start(sel, 1'b1);
          data = inj_data;
        end else if (inj_kind == 2) begin
          rst_n = 1'b0;
        end
      end
    end
    set_start(sel, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    start0 = 1'b1;
    start1 = 1'b1;
    rst_n  = 1'b0;
    data   = 8'($urandom);
    repeat (3) @(negedge clk);
    compared++;
    if ({tx0, busy0, done0} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL reset_dut0: got tx/busy/done=%b, expected 100", {tx0, busy0, done0});
    end
    compared++;
    if ({tx1, busy1, done1} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL reset_dut1: got tx/busy/done=%b, expected 100", {tx1, busy1, done1});
    end
    start0 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({tx0, busy0, done0} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL reset_start_ignored_dut0: got tx/busy/done=%b, expected 100", {tx0, busy0, done0});
    end
    compared++;
    if ({tx1, busy1, done1} !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL reset_start_ignored_dut1: got tx/busy/done=%b, expected 100", {tx1, busy1, done1});
    end
  endtask

  task automatic test_basic_frame();
    int len, n, d;
    len = frame_len(8, 1);
    n   = len + 3;
    clear_exp();
    add_frame(0, 8'h55, 8, 1);
    capture(0, n, 8'h55, 0, 8'($urandom), 0, 0, 8'h00);
    for (int w = 0; w < 3; w++) begin
      d = first_diff(n, w);
      compared++;
      if (d != -1) begin
        mismatched++;
        $display("[TB] FAIL basic_0x55 %s at T+%0d: got %b, expected %b", sig_name(w), d, cap_val(w, d), exp_val(w, d));
      end
    end
    compared++;
    if ({cap_tx[BC], cap_tx[BC+1], cap_tx[2*BC+1]} !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL basic_edges: got start-end/bit0/bit1=%b, expected 010", {cap_tx[BC], cap_tx[BC+1], cap_tx[2*BC+1]});
    end
  endtask

  task automatic test_start_ignored();
    int len, n, d;
    len = frame_len(8, 1);
    n   = len + 3;
    clear_exp();
    add_frame(0, 8'hA3, 8, 1);
    capture(0, n, 8'hA3, 0, 8'($urandom), 500, 1, 8'hFF);
    for (int w = 0; w < 3; w++) begin
      d = first_diff(n, w);
      compared++;
      if (d != -1) begin
        mismatched++;
        $display("[TB] FAIL start_ignored %s at T+%0d: got %b, expected %b", sig_name(w), d, cap_val(w, d), exp_val(w, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    int len, n, d;
    len = frame_len(8, 1);
    n   = 2 * len + 3;
    clear_exp();
    add_frame(0, 8'h01, 8, 1);
    add_frame(len + 1, 8'h80, 8, 1);
    capture(0, n, 8'h01, len + 1, 8'h80, 0, 0, 8'h00);
    for (int w = 0; w < 3; w++) begin
      d = first_diff(n, w);
      compared++;
      if (d != -1) begin
        mismatched++;
        $display("[TB] FAIL back_to_back %s at T+%0d: got %b, expected %b", sig_name(w), d, cap_val(w, d), exp_val(w, d));
      end
    end
    compared++;
    if ({cap_done[len], cap_tx[len+1], cap_tx[len+2]} !== 3'b110) begin
      mismatched++;
      $display("[TB] FAIL back_to_back_gap: got done/idle/start=%b, expected 110", {cap_done[len], cap_tx[len+1], cap_tx[len+2]});
    end
  endtask

  task automatic test_reset_mid_frame();
    int         len, n, d;
    logic [7:0] v;
    len = frame_len(8, 1);
    n   = len + 3;
    v   = 8'($urandom);
    clear_exp();
    add_frame(0, v, 8, 1);
    for (int k = 301; k <= n; k++) begin
      exp_tx[k]   = 1'b1;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
    capture(0, n, v, 0, 8'($urandom), 300, 2, 8'h00);
    for (int w = 0; w < 3; w++) begin
      d = first_diff(n, w);
      compared++;
      if (d != -1) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_frame data=%h %s at T+%0d: got %b, expected %b", v, sig_name(w), d, cap_val(w, d), exp_val(w, d));
      end
    end
    v = 8'($urandom);
    clear_exp();
    add_frame(0, v, 8, 1);
    capture(0, n, v, 0, 8'($urandom), 0, 0, 8'h00);
    for (int w = 0; w < 3; w++) begin
      d = first_diff(n, w);
      compared++;
      if (d != -1) begin
        mismatched++;
        $display("[TB] FAIL after_reset data=%h %s at T+%0d: got %b, expected %b", v, sig_name(w), d, cap_val(w, d), exp_val(w, d));
      end
    end
  endtask

  task automatic test_random_frames();
    int         len, n, d;
    logic [7:0] v;
    len = frame_len(8, 1);
    n   = len + 3;
    for (int f = 0; f < 3; f++) begin
      v = 8'($urandom);
      clear_exp();
      add_frame(0, v, 8, 1);
      capture(0, n, v, 0, 8'($urandom), 0, 0, 8'h00);
      for (int w = 0; w < 3; w++) begin
        d = first_diff(n, w);
        compared++;
        if (d != -1) begin
          mismatched++;
          $display("[TB] FAIL random data=%h %s at T+%0d: got %b, expected %b", v, sig_name(w), d, cap_val(w, d), exp_val(w, d));
        end
      end
    end
  endtask

  task automatic test_parity_bits();
    int         len, n, d;
    logic [7:0] vals[2];
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    len = frame_len(8, 1);
    n   = len + 3;
    for (int f = 0; f < 2; f++) begin
      clear_exp();
      add_frame(0, vals[f], 8, 1);
      capture(0, n, vals[f], 0, ~vals[f], 0, 0, 8'h00);
      for (int w = 0; w < 3; w++) begin
        d = first_diff(n, w);
        compared++;
        if (d != -1) begin
          mismatched++;
          $display("[TB] FAIL parity data=%h %s at T+%0d: got %b, expected %b", vals[f], sig_name(w), d, cap_val(w, d), exp_val(w, d));
        end
      end
    end
  endtask

  task automatic test_short_frame();
    int         len, n, d;
    logic [7:0] vals[2];
    vals[0] = 8'h41;
    vals[1] = 8'($urandom);
    len = frame_len(7, 2);
    n   = len + 3;
    for (int f = 0; f < 2; f++) begin
      clear_exp();
      add_frame(0, vals[f], 7, 2);
      capture(1, n, vals[f], 0, 8'($urandom), 0, 0, 8'h00);
      for (int w = 0; w < 3; w++) begin
        d = first_diff(n, w);
        compared++;
        if (d != -1) begin
          mismatched++;
          $display("[TB] FAIL d7_sp2 data=%h %s at T+%0d: got %b, expected %b", vals[f][6:0], sig_name(w), d, cap_val(w, d), exp_val(w, d));
        end
      end
    end
  endtask

  initial begin
    $display("[TB] tx_top bench, BIT_CYCLES=%0d parity=%0d", BC, PAR);
    test_reset();
    test_basic_frame();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    test_parity_bits();
    test_short_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
